// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Round-robin arbiter that funnels NUM_PORTS requester ports into one
//   registered memory request channel. It tags each request with a
//   transaction ID {port[1:0], seq[13:0]}, tracks in-flight requests per
//   port, and routes memory responses back to the port named in the ID.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clk edge where valid && ready are both high. The valid side holds
// its payload stable until that edge.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   p_req_valid / p_req_ready   per-port request handshake (ready = grant)
//   p_req_warp_id/we/addr/wdata/mask  per-port payload, flattened by port
//   mem_req_valid / mem_req_ready     memory request handshake
//   mem_req_*                   registered request payload and transaction ID
//   mem_resp_*                  single-cycle memory response, no backpressure
//   p_resp_valid                one-hot response strobe, one cycle
//   p_resp_*                    shared response payload
//   p_outstanding               per-port in-flight count, 4 bits per port
//   err                         sticky flag for unroutable responses
module mem_req_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_PORTS-1:0]      p_req_valid,
    output logic [NUM_PORTS-1:0]      p_req_ready,
    input  logic [NUM_PORTS*5-1:0]    p_req_warp_id,
    input  logic [NUM_PORTS-1:0]      p_req_we,
    input  logic [NUM_PORTS*32-1:0]   p_req_addr,
    input  logic [NUM_PORTS*1024-1:0] p_req_wdata,
    input  logic [NUM_PORTS*32-1:0]   p_req_mask,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [4:0]                mem_req_warp_id,
    output logic [15:0]               mem_req_transaction_id,
    output logic                      mem_req_we,
    output logic [31:0]               mem_req_addr,
    output logic [1023:0]             mem_req_wdata,
    output logic [31:0]               mem_req_mask,
    input  logic                      mem_resp_valid,
    input  logic [4:0]                mem_resp_warp_id,
    input  logic [15:0]               mem_resp_transaction_id,
    input  logic [1023:0]             mem_resp_rdata,
    output logic [NUM_PORTS-1:0]      p_resp_valid,
    output logic [4:0]                p_resp_warp_id,
    output logic [15:0]               p_resp_transaction_id,
    output logic [1023:0]             p_resp_rdata,
    output logic [NUM_PORTS*4-1:0]    p_outstanding,
    output logic                      err
);

    logic [3:0]           cnt_q [NUM_PORTS];
    logic [13:0]          seq_q [NUM_PORTS];
    logic [1:0]           rr_ptr_q;
    logic [1:0]           rr_next;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic                 grant_any;
    logic                 or_free;
    logic [NUM_PORTS-1:0] resp_dec;
    logic                 resp_bad;
    logic [1:0]           resp_port;

    logic [4:0]           sel_warp_id;
    logic [15:0]          sel_tid;
    logic                 sel_we;
    logic [31:0]          sel_addr;
    logic [1023:0]        sel_wdata;
    logic [31:0]          sel_mask;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign eligible[g]             = p_req_valid[g] && (cnt_q[g] < 4'(MAX_OUTSTANDING));
        assign p_outstanding[g*4 +: 4] = cnt_q[g];
    end

    assign p_req_ready = grant;

    // Arbitration: the output register is free when empty or draining this
    // cycle, which lets a new request load in the same cycle as the accept.
    always_comb begin
        int idx;
        or_free     = !mem_req_valid || mem_req_ready;
        grant       = '0;
        grant_any   = 1'b0;
        rr_next     = rr_ptr_q;
        idx         = 0;
        sel_warp_id = '0;
        sel_tid     = '0;
        sel_we      = 1'b0;
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_mask    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            // rst_n gating keeps p_req_ready low while reset is held.
            if (rst_n && or_free && !grant_any && eligible[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                rr_next    = (idx == NUM_PORTS - 1) ? 2'd0 : 2'(idx + 1);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_warp_id = p_req_warp_id[i*5 +: 5];
                sel_tid     = {2'(i), seq_q[i]};
                sel_we      = p_req_we[i];
                sel_addr    = p_req_addr[i*32 +: 32];
                sel_wdata   = p_req_wdata[i*1024 +: 1024];
                sel_mask    = p_req_mask[i*32 +: 32];
            end
        end
    end

    // Response decode: a response is routable only if its port exists and
    // that port has something in flight; anything else is a protocol error.
    always_comb begin
        resp_port = mem_resp_transaction_id[15:14];
        resp_dec  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (mem_resp_valid && resp_port == 2'(i) && cnt_q[i] != 4'd0)
                resp_dec[i] = 1'b1;
        end
        resp_bad = mem_resp_valid && (resp_dec == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_valid          <= 1'b0;
            mem_req_warp_id        <= '0;
            mem_req_transaction_id <= '0;
            mem_req_we             <= 1'b0;
            mem_req_addr           <= '0;
            mem_req_wdata          <= '0;
            mem_req_mask           <= '0;
            p_resp_valid           <= '0;
            p_resp_warp_id         <= '0;
            p_resp_transaction_id  <= '0;
            p_resp_rdata           <= '0;
            rr_ptr_q               <= '0;
            err                    <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
                seq_q[i] <= '0;
            end
        end else begin
            if (grant_any) begin
                mem_req_valid          <= 1'b1;
                mem_req_warp_id        <= sel_warp_id;
                mem_req_transaction_id <= sel_tid;
                mem_req_we             <= sel_we;
                mem_req_addr           <= sel_addr;
                mem_req_wdata          <= sel_wdata;
                mem_req_mask           <= sel_mask;
                rr_ptr_q               <= rr_next;
            end else if (mem_req_ready) begin
                mem_req_valid <= 1'b0;
            end

            p_resp_valid <= resp_dec;
            if (resp_dec != '0) begin
                p_resp_warp_id        <= mem_resp_warp_id;
                p_resp_transaction_id <= mem_resp_transaction_id;
                p_resp_rdata          <= mem_resp_rdata;
            end
            if (resp_bad) err <= 1'b1;

            for (int i = 0; i < NUM_PORTS; i++) begin
                case ({grant[i], resp_dec[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + 4'd1;
                    2'b01:   cnt_q[i] <= cnt_q[i] - 4'd1;
                    default: cnt_q[i] <= cnt_q[i];
                endcase
                if (grant[i]) seq_q[i] <= seq_q[i] + 14'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: a vector table covering the round-robin
// sweep and response routing, then hand-written sequences for backpressure,
// the in-flight limit, simultaneous grant/response, error stickiness,
// mid-transfer reset and sequence-number wrap.
module tb_mem_req_arbiter;

    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     p_req_valid;
    logic [NP-1:0]     p_req_ready;
    logic [NP*5-1:0]   p_req_warp_id;
    logic [NP-1:0]     p_req_we;
    logic [NP*32-1:0]  p_req_addr;
    logic [NP*1024-1:0] p_req_wdata;
    logic [NP*32-1:0]  p_req_mask;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [4:0]        mem_req_warp_id;
    logic [15:0]       mem_req_transaction_id;
    logic              mem_req_we;
    logic [31:0]       mem_req_addr;
    logic [1023:0]     mem_req_wdata;
    logic [31:0]       mem_req_mask;
    logic              mem_resp_valid;
    logic [4:0]        mem_resp_warp_id;
    logic [15:0]       mem_resp_transaction_id;
    logic [1023:0]     mem_resp_rdata;
    logic [NP-1:0]     p_resp_valid;
    logic [4:0]        p_resp_warp_id;
    logic [15:0]       p_resp_transaction_id;
    logic [1023:0]     p_resp_rdata;
    logic [NP*4-1:0]   p_outstanding;
    logic              err;

    int total  = 0;
    int passed = 0;

    mem_req_arbiter #(.NUM_PORTS(NP), .MAX_OUTSTANDING(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req_valid(p_req_valid), .p_req_ready(p_req_ready),
        .p_req_warp_id(p_req_warp_id), .p_req_we(p_req_we),
        .p_req_addr(p_req_addr), .p_req_wdata(p_req_wdata), .p_req_mask(p_req_mask),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_warp_id(mem_req_warp_id), .mem_req_transaction_id(mem_req_transaction_id),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_mask(mem_req_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_warp_id(mem_resp_warp_id),
        .mem_resp_transaction_id(mem_resp_transaction_id), .mem_resp_rdata(mem_resp_rdata),
        .p_resp_valid(p_resp_valid), .p_resp_warp_id(p_resp_warp_id),
        .p_resp_transaction_id(p_resp_transaction_id), .p_resp_rdata(p_resp_rdata),
        .p_outstanding(p_outstanding), .err(err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_wide(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got low word %h expected low word %h", name, act[31:0], exp[31:0]);
    endtask

    // ---------------- drivers ----------------
    // Inputs change just after the falling edge; checks run 1 time unit later,
    // well away from the rising edge.
    task automatic drive(input logic [3:0] v, input logic rdy, input logic rv, input logic [15:0] rtid);
        @(negedge clk);
        p_req_valid             = v;
        mem_req_ready           = rdy;
        mem_resp_valid          = rv;
        mem_resp_transaction_id = rtid;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        p_req_valid    = 4'b1111;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        #1;
        check("ready_in_reset", 32'(p_req_ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        p_req_valid = '0;
        #1;
        check("rst_mem_valid", 32'(mem_req_valid), 32'h0);
        check("rst_outstanding", 32'(p_outstanding), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_resp_valid", 32'(p_resp_valid), 32'h0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  valid;
        logic        ready;
        logic        rv;
        logic [15:0] rtid;
        logic [3:0]  e_rdy;
        logic        e_mv;
        logic [15:0] e_tid;
        logic [3:0]  e_prv;
        logic [15:0] e_out;
    } vec_t;

    vec_t vecs[11];
    logic [1023:0] rd_pat;

    initial begin
        // Row fields: valid, mem_ready, resp_v, resp_tid |
        //   expected p_req_ready, mem_req_valid, mem_req_tid, p_resp_valid, p_outstanding
        vecs[0]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b0001, 1'b0, 16'h0000, 4'b0000, 16'h0000};
        vecs[1]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b1, 16'h0000, 4'b0000, 16'h0001};
        vecs[2]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b0100, 1'b1, 16'h4000, 4'b0000, 16'h0011};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b1000, 1'b1, 16'h8000, 4'b0000, 16'h0111};
        vecs[4]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b0001, 1'b1, 16'hC000, 4'b0000, 16'h1111};
        vecs[5]  = '{4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1, 16'h0001, 4'b0000, 16'h1112};
        vecs[6]  = '{4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0001, 4'b0000, 16'h1112};
        vecs[7]  = '{4'b0000, 1'b1, 1'b1, 16'h4000, 4'b0000, 1'b0, 16'h0001, 4'b0000, 16'h1112};
        vecs[8]  = '{4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0001, 4'b0010, 16'h1102};
        vecs[9]  = '{4'b0000, 1'b1, 1'b1, 16'h0000, 4'b0000, 1'b0, 16'h0001, 4'b0000, 16'h1102};
        vecs[10] = '{4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0001, 4'b0001, 16'h1101};

        // Static per-port payload so the payload path can be checked by port.
        for (int i = 0; i < NP; i++) begin
            p_req_warp_id[i*5 +: 5]     = 5'(i + 3);
            p_req_we[i]                 = i[0];
            p_req_addr[i*32 +: 32]      = 32'h1000_0000 + 32'(i * 256);
            p_req_wdata[i*1024 +: 1024] = {32{32'hA5A5_0000 + 32'(i)}};
            p_req_mask[i*32 +: 32]      = 32'hFFFF_0000 | 32'(i);
        end
        rst_n                   = 1'b0;
        p_req_valid             = '0;
        mem_req_ready           = 1'b0;
        mem_resp_valid          = 1'b0;
        mem_resp_warp_id        = 5'd0;
        mem_resp_transaction_id = 16'h0;
        mem_resp_rdata          = '0;

        // ---- table: round-robin sweep, IDs, response routing ----
        do_reset();
        for (int r = 0; r < 11; r++) begin
            drive(vecs[r].valid, vecs[r].ready, vecs[r].rv, vecs[r].rtid);
            check($sformatf("vec%0d_ready", r), 32'(p_req_ready), 32'(vecs[r].e_rdy));
            check($sformatf("vec%0d_mvalid", r), 32'(mem_req_valid), 32'(vecs[r].e_mv));
            check($sformatf("vec%0d_tid", r), 32'(mem_req_transaction_id), 32'(vecs[r].e_tid));
            check($sformatf("vec%0d_resp_valid", r), 32'(p_resp_valid), 32'(vecs[r].e_prv));
            check($sformatf("vec%0d_outstanding", r), 32'(p_outstanding), 32'(vecs[r].e_out));
        end
        check("vec_err", 32'(err), 32'h0);

        // ---- backpressure: port 2 held for 3 stalled cycles ----
        do_reset();
        drive(4'b0100, 1'b0, 1'b0, 16'h0);
        check("bp_first_grant", 32'(p_req_ready), 32'h4);
        for (int c = 0; c < 3; c++) begin
            drive(4'b0100, 1'b0, 1'b0, 16'h0);
            check("bp_hold_valid", 32'(mem_req_valid), 32'h1);
            check("bp_hold_tid", 32'(mem_req_transaction_id), 32'h8000);
            check("bp_hold_addr", mem_req_addr, 32'h1000_0200);
            check("bp_hold_no_grant", 32'(p_req_ready), 32'h0);
        end
        drive(4'b0100, 1'b1, 1'b0, 16'h0);
        check("bp_accept_valid", 32'(mem_req_valid), 32'h1);
        check("bp_accept_regrant", 32'(p_req_ready), 32'h4);
        check("bp_warp", 32'(mem_req_warp_id), 32'd5);
        check("bp_mask", mem_req_mask, 32'hFFFF_0002);
        check_wide("bp_wdata", mem_req_wdata, {32{32'hA5A5_0002}});
        drive(4'b0000, 1'b1, 1'b0, 16'h0);
        check("bp_reload_tid", 32'(mem_req_transaction_id), 32'h8001);
        check("bp_reload_valid", 32'(mem_req_valid), 32'h1);

        // ---- in-flight limit on port 1 ----
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(4'b0010, 1'b1, 1'b0, 16'h0);
            check("lim_grant", 32'(p_req_ready), 32'h2);
        end
        rd_pat = {16{64'hDEAD_BEEF_0123_4567}};
        mem_resp_rdata   = rd_pat;
        mem_resp_warp_id = 5'd9;
        drive(4'b0010, 1'b1, 1'b1, 16'h4000);
        check("lim_held", 32'(p_req_ready), 32'h0);
        check("lim_count8", 32'(p_outstanding[7:4]), 32'd8);
        check("lim_last_tid", 32'(mem_req_transaction_id), 32'h4007);
        drive(4'b0010, 1'b1, 1'b0, 16'h0);
        check("lim_resp_valid", 32'(p_resp_valid), 32'h2);
        check("lim_resp_tid", 32'(p_resp_transaction_id), 32'h4000);
        check("lim_resp_warp", 32'(p_resp_warp_id), 32'd9);
        check_wide("lim_resp_rdata", p_resp_rdata, rd_pat);
        check("lim_count7", 32'(p_outstanding[7:4]), 32'd7);
        check("lim_resume", 32'(p_req_ready), 32'h2);

        // ---- grant and response to port 0 in one cycle ----
        do_reset();
        for (int c = 0; c < 3; c++) drive(4'b0001, 1'b1, 1'b0, 16'h0);
        drive(4'b0001, 1'b1, 1'b1, 16'h0000);
        check("both_count_before", 32'(p_outstanding[3:0]), 32'd3);
        check("both_grant", 32'(p_req_ready), 32'h1);
        drive(4'b0000, 1'b1, 1'b0, 16'h0);
        check("both_count_after", 32'(p_outstanding[3:0]), 32'd3);
        check("both_resp_valid", 32'(p_resp_valid), 32'h1);

        // ---- mid-transfer reset, then stale response sets sticky err ----
        do_reset();
        drive(4'b0001, 1'b0, 1'b0, 16'h0);
        drive(4'b0000, 1'b0, 1'b0, 16'h0);
        check("mid_valid_before", 32'(mem_req_valid), 32'h1);
        check("mid_count_before", 32'(p_outstanding[3:0]), 32'd1);
        do_reset();
        drive(4'b0000, 1'b1, 1'b1, 16'h0005);
        drive(4'b0000, 1'b1, 1'b0, 16'h0);
        check("err_no_strobe", 32'(p_resp_valid), 32'h0);
        check("err_set", 32'(err), 32'h1);
        check("err_no_count", 32'(p_outstanding), 32'h0);
        for (int c = 0; c < 3; c++) drive(4'b0000, 1'b1, 1'b0, 16'h0);
        check("err_sticky", 32'(err), 32'h1);
        do_reset();
        check("err_cleared", 32'(err), 32'h0);

        // ---- 16384 grants on port 3: sequence wraps ----
        // One response per cycle after the first grant keeps the count at 1.
        do_reset();
        for (int g = 0; g <= 16385; g++) begin
            drive(4'b1000, 1'b1, (g >= 1), 16'hC000);
            if (g == 16384) check("wrap_last_tid", 32'(mem_req_transaction_id), 32'hFFFF);
            if (g == 16385) check("wrap_next_tid", 32'(mem_req_transaction_id), 32'hC000);
        end
        check("wrap_count", 32'(p_outstanding[15:12]), 32'd1);
        check("wrap_err", 32'(err), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
